// File: rtl/simon_pkg.sv
// simon_pkg: shared Simon 96/96 parameters, z2 sequence and FSM state type.
package simon_pkg;
    localparam int N_DEF = 48;
    localparam int M_DEF = 2;
    localparam int ROUNDS_DEF = 52;
    localparam logic [61:0] Z2 = 62'h3369f885192c0ef5;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
endpackage

// File: rtl/simon_key_expand.sv
// simon_key_expand: combinational next round key for the two-word Simon key schedule.
module simon_key_expand import simon_pkg::*; #(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] ka,
    input  logic [N-1:0] kb,
    input  logic [5:0]   idx,
    output logic [N-1:0] kb_next
);
    logic [N-1:0] t;
    always_comb begin
        t = {kb[2:0], kb[N-1:3]};
        kb_next = ~ka ^ t ^ {t[0], t[N-1:1]} ^ N'(Z2[idx]) ^ N'(3);
    end
endmodule

// File: rtl/simon_encrypt_engine.sv
// simon_encrypt_engine: iterative Simon 96/96 encryptor, one round per clock; SIMON_ABORT_EN adds an abort input.
module simon_encrypt_engine import simon_pkg::*; #(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic           clk,
    input  logic           rst,
`ifdef SIMON_ABORT_EN
    input  logic           abort,
`endif
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] pt,
    input  logic [N*M-1:0] key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] ct,
    output logic           busy
);
    localparam int W = $clog2(ROUNDS);
    fsm_e           fsm_q, fsm_d;
    logic [2*N-1:0] state_q, state_d;
    logic [N-1:0]   ka_q, ka_d, kb_q, kb_d, kb_next, x1, f;
    logic [W-1:0]   rnd_q, rnd_d;
    logic [5:0]     z_idx;
    assign z_idx = 6'(32'(rnd_q) % 32'd62);
    simon_key_expand #(.N(N)) u_key (.ka(ka_q), .kb(kb_q), .idx(z_idx), .kb_next(kb_next));
    always_comb begin
        x1 = state_q[2*N-1:N];
        f = ({x1[N-2:0], x1[N-1]} & {x1[N-9:0], x1[N-1:N-8]}) ^ {x1[N-3:0], x1[N-1:N-2]};
        fsm_d = fsm_q;
        state_d = state_q;
        ka_d = ka_q;
        kb_d = kb_q;
        rnd_d = rnd_q;
        case (fsm_q)
            IDLE: if (in_valid) begin
                state_d = pt;
                ka_d = key[N-1:0];
                kb_d = key[2*N-1:N];
                rnd_d = '0;
                fsm_d = RUN;
            end
            RUN: begin
                state_d = {state_q[N-1:0] ^ f ^ ka_q, x1};
                ka_d = kb_q;
                kb_d = kb_next;
                rnd_d = rnd_q + 1'b1;
                fsm_d = (rnd_q == W'(ROUNDS - 1)) ? DONE : RUN;
`ifdef SIMON_ABORT_EN
                if (abort) begin
                    fsm_d = IDLE;
                    rnd_d = '0;
                end
`endif
            end
            DONE: fsm_d = out_ready ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
            state_q <= '0;
            ka_q <= '0;
            kb_q <= '0;
            rnd_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            state_q <= state_d;
            ka_q <= ka_d;
            kb_q <= kb_d;
            rnd_q <= rnd_d;
        end
    end
    assign ct = state_q;
    assign in_ready = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy = (fsm_q == RUN);
endmodule

// File: doc/simon_encrypt_engine.md
SIMON_ENCRYPT_ENGINE -- requirements
Module: simon_encrypt_engine

Interface
REQ-001 SHALL have parameter N, default 48, word width in bits.
REQ-002 SHALL have parameter M, default 2, key words; only M=2 is supported.
REQ-003 SHALL have parameter ROUNDS, default 52, rounds per block (Simon 96/96).
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: pt and key are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: engine accepts a block.
REQ-008 SHALL have port pt, input, 2N bits: plaintext; [2N-1:N] is x1 (upper word), [N-1:0] is x0.
REQ-009 SHALL have port key, input, N*M bits: [N-1:0] is k0, [2N-1:N] is k1.
REQ-010 SHALL have port out_valid, output, 1 bit: ct is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts ct.
REQ-012 SHALL have port ct, output, 2N bits: ciphertext, same word order as pt.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL drive out_valid=1 only in DONE.
REQ-017 SHALL drive busy=1 only in RUN.
REQ-018 SHALL, on an IDLE edge with in_valid=1, load state<=pt, ka<=k0, kb<=k1, rnd<=0, and go to RUN.
REQ-019 SHALL, on each RUN edge, set state <= {x0 ^ (S1(x1)&S8(x1)) ^ S2(x1) ^ ka, x1}, where Sj is a left rotate by j within N bits.
REQ-020 SHALL, on each RUN edge, set ka<=kb and kb<=~ka ^ t ^ S^-1(t) ^ z2[rnd mod 62] ^ 3, where t=S^-3(kb) and S^-j is a right rotate.
REQ-021 SHALL, on each RUN edge, set rnd<=rnd+1; rnd is $clog2(ROUNDS) bits wide.
REQ-022 SHALL, on the RUN edge with rnd==ROUNDS-1, apply the last round and go to DONE; out_valid rises exactly ROUNDS cycles after the accept edge.
REQ-023 SHALL drive ct directly from the state register; ct holds its value throughout DONE.
REQ-024 SHALL, in DONE with out_ready=1, go to IDLE; with out_ready=0 it stays in DONE indefinitely (backpressure).
REQ-025 SHALL ignore in_valid outside IDLE; pt and key are sampled only at accept and may change afterwards.
REQ-026 SHALL sustain a minimum block interval of ROUNDS+2 cycles; a new block is not accepted in the cycle DONE exits.
REQ-027 SHALL treat out_ready as don't-care outside DONE.
REQ-028 SHALL compute all arithmetic modulo 2^N; z2 index wraps at 62 without overflow.

Reset
REQ-029 SHALL, while rst=1 on a clk edge, force the FSM to IDLE, rnd=0, and state, ka and kb to 0.
REQ-030 SHALL produce outputs in_ready=1, out_valid=0, busy=0, ct=0 after reset.
REQ-031 SHALL let rst in RUN or DONE abandon the block and never emit it.
REQ-032 SHALL give rst priority over in_valid and out_ready.

Configuration
REQ-033 SHALL, with macro SIMON_ABORT_EN defined, add input abort (1 bit); abort=1 on a RUN edge returns the FSM to IDLE, clears rnd, and emits no output.
REQ-034 SHALL treat abort as ignored in IDLE and DONE, with rst taking priority.
REQ-035 SHALL, without SIMON_ABORT_EN, have no abort port, and RUN always completes.

Structure
REQ-036 SHALL take N, M, ROUNDS defaults, the 62-bit z2 constant (bit 0 = first sequence bit) and the FSM state enum from shared package simon_pkg.
REQ-037 SHALL implement the next-key computation of REQ-020 as one combinational sub-module, simon_key_expand, which is instantiated once.
REQ-038 SHALL implement the round function inline.

Verification
REQ-039 SHALL pass a known-answer test: key=0x0d0c0b0a0908_050403020100, pt=0x2072616c6c69_702065687420 -> ct=0x602807a462b4_69063d8ff082, out_valid at accept+52 cycles.
REQ-040 SHALL pass a backpressure test: hold out_ready=0 for 20 cycles after out_valid -> ct stable, in_ready=0, then one-cycle out_ready -> IDLE.
REQ-041 SHALL pass a reset mid-RUN test: assert rst at round 10 -> next cycle in_ready=1, busy=0, ct=0; a following KAT block still matches.
REQ-042 SHALL pass a back-to-back test: in_valid held high with two blocks -> second accepted exactly 54 cycles after the first; both ct correct.
REQ-043 SHALL pass an input-change test: change pt/key every cycle during RUN -> ct equals the value for the accepted inputs.
REQ-044 SHALL pass an abort test with SIMON_ABORT_EN: abort at round 5 -> IDLE next cycle, no out_valid, next block correct.
